load_store_unit: RTL and testbench

Data-side memory adapter between the CPU datapath and a handshaked data memory. It takes the CPU's load/store request (ALU-computed address, rs2 data, funct3), aligns byte/halfword/word accesses onto a 32-bit word bus with byte strobes, and sign- or zero-extends returned load data. It stalls the CPU until the access completes and reports misaligned, illegal or timed-out accesses as a fault. It replaces the zero-latency `memory` path so the core can run against memories with wait states.

---
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Word-wide data-memory bus between the load/store unit and a handshaked memory.
interface load_store_unit_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // LSU side: issues requests and consumes read responses.
  modport master (
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  // Memory side.
  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: aligns CPU byte/half/word accesses onto a 32-bit strobed bus,
// extends load data, stalls the CPU until completion and flags faults.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_fault,
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic        mem_valid_q, mem_valid_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  off_q, off_d;       // byte offset, kept for load lane select
  logic [2:0]  f3_q, f3_d;         // funct3, kept for load extension
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_fault_q, cpu_fault_d;

  logic        legal;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [8:0]  tmo_inc;
  logic        tmo_hit;

  assign cpu_stall     = cpu_req && (state_q != DONE);
  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_fault     = cpu_fault_q;
  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign tmo_inc = {1'b0, tmo_q} + 9'd1;
  assign tmo_hit = (tmo_inc == 9'(TIMEOUT_CYCLES));

  // Legality: known funct3, no unsigned stores, natural alignment for h/w.
  always_comb begin
    legal = 1'b0;
    case (cpu_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = !cpu_addr[0];
      3'b010:  legal = (cpu_addr[1:0] == 2'b00);
      3'b100:  legal = !cpu_we;
      3'b101:  legal = !cpu_we && !cpu_addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Store lane replication and strobes; loads carry no strobes or data.
  always_comb begin
    st_strb = 4'b0000;
    st_data = 32'h0;
    if (cpu_we) begin
      case (cpu_funct3[1:0])
        2'b00: begin
          st_strb = 4'b0001 << cpu_addr[1:0];
          st_data = {4{cpu_wdata[7:0]}};
        end
        2'b01: begin
          st_strb = cpu_addr[1] ? 4'b1100 : 4'b0011;
          st_data = {2{cpu_wdata[15:0]}};
        end
        default: begin
          st_strb = 4'b1111;
          st_data = cpu_wdata;
        end
      endcase
    end
  end

  // Load lane select and sign/zero extension of the returned word.
  always_comb begin
    ld_byte = mem.mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = mem.mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem.mem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    off_d       = off_q;
    f3_d        = f3_q;
    tmo_d       = tmo_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_fault_d = cpu_fault_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (!legal) begin
            state_d     = DONE;
            cpu_fault_d = 1'b1;
            cpu_rdata_d = 32'h0;
          end else begin
            state_d     = REQ;
            mem_we_d    = cpu_we;
            mem_addr_d  = {cpu_addr[31:2], 2'b00};
            mem_wstrb_d = st_strb;
            mem_wdata_d = st_data;
            off_d       = cpu_addr[1:0];
            f3_d        = cpu_funct3;
            tmo_d       = 8'h0;
          end
        end
      end
      REQ: begin
        tmo_d = tmo_inc[7:0];
        // Acceptance wins over a timeout landing on the same cycle.
        if (mem.mem_ready) begin
          if (mem_we_q) begin
            state_d     = DONE;
            cpu_fault_d = 1'b0;
            cpu_rdata_d = 32'h0;
          end else begin
            state_d = RESP;
          end
        end else if (tmo_hit) begin
          state_d     = DONE;
          cpu_fault_d = 1'b1;
          cpu_rdata_d = 32'h0;
        end
      end
      RESP: begin
        tmo_d = tmo_inc[7:0];
        if (mem.mem_rvalid) begin
          state_d     = DONE;
          cpu_fault_d = 1'b0;
          cpu_rdata_d = ld_ext;
        end else if (tmo_hit) begin
          state_d     = DONE;
          cpu_fault_d = 1'b1;
          cpu_rdata_d = 32'h0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Request is presented exactly while the FSM sits in REQ.
    mem_valid_d = (state_d == REQ);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'h0;
      mem_wdata_q <= 32'h0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      tmo_q       <= 8'h0;
      cpu_rdata_q <= 32'h0;
      cpu_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      tmo_q       <= tmo_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_fault_q <= cpu_fault_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_fault;
  int          n_pass = 0;
  int          n_total = 0;

  load_store_unit_if mif();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_fault(cpu_fault), .mem(mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd;
  endtask

  // Load with ready=1; a bogus rvalid is driven in IDLE and in the acceptance
  // cycle, and the real response arrives the cycle after acceptance.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] ea, input logic [31:0] rd,
                         input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    mif.mem_ready = 1'b1; mif.mem_rvalid = 1'b1; mif.mem_rdata = ~rd;
    #1 chk({tag, "_stall_c0"}, cpu_stall, 1);
    cyc();
    chk({tag, "_valid"}, mif.mem_valid, 1);
    chk({tag, "_addr"}, mif.mem_addr, ea);
    chk({tag, "_wstrb"}, mif.mem_wstrb, 0);
    mif.mem_rdata = rd;
    cyc();
    chk({tag, "_stall_resp"}, cpu_stall, 1);
    chk({tag, "_valid_resp"}, mif.mem_valid, 0);
    cyc();
    mif.mem_rvalid = 1'b0;
    chk({tag, "_rdata"}, cpu_rdata, exp);
    chk({tag, "_fault"}, cpu_fault, 0);
    chk({tag, "_stall_done"}, cpu_stall, 0);
    cpu_req = 1'b0;
    cyc();
  endtask

  task automatic do_illegal(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] a);
    issue(we, f3, a, 32'hFFFF_FFFF);
    mif.mem_ready = 1'b1;
    #1 chk({tag, "_stall_c0"}, cpu_stall, 1);
    cyc();
    chk({tag, "_valid"}, mif.mem_valid, 0);
    chk({tag, "_fault"}, cpu_fault, 1);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_stall_done"}, cpu_stall, 0);
    cpu_req = 1'b0;
    cyc();
    chk({tag, "_valid_after"}, mif.mem_valid, 0);
  endtask

  initial begin
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'b000;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;
    mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    #2;
    chk("rst_valid", mif.mem_valid, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_fault", cpu_fault, 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_wstrb", mif.mem_wstrb, 0);
    cpu_req = 1'b1;
    #1 chk("rst_stall_follows_req", cpu_stall, 1);
    cpu_req = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // sb to 0x6
    issue(1'b1, 3'b000, 32'h0000_0006, 32'h1234_56AB);
    mif.mem_ready = 1'b1;
    #1 chk("sb_stall_c0", cpu_stall, 1);
    cyc();
    chk("sb_valid", mif.mem_valid, 1);
    chk("sb_we", mif.mem_we, 1);
    chk("sb_addr", mif.mem_addr, 32'h4);
    chk("sb_wstrb", mif.mem_wstrb, 4'b0100);
    chk("sb_wdata", mif.mem_wdata, 32'hABAB_ABAB);
    chk("sb_stall_c1", cpu_stall, 1);
    cyc();
    chk("sb_stall_done", cpu_stall, 0);
    chk("sb_fault", cpu_fault, 0);
    chk("sb_valid_done", mif.mem_valid, 0);
    cpu_req = 1'b0;
    cyc();

    // sw with ready held low for 3 cycles
    issue(1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF);
    mif.mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("swh_valid", mif.mem_valid, 1);
      chk("swh_addr", mif.mem_addr, 32'h20);
      chk("swh_wstrb", mif.mem_wstrb, 4'b1111);
      chk("swh_wdata", mif.mem_wdata, 32'hDEAD_BEEF);
      chk("swh_stall", cpu_stall, 1);
      if (i == 3) mif.mem_ready = 1'b1;
      cyc();
    end
    chk("swh_stall_done", cpu_stall, 0);
    chk("swh_fault", cpu_fault, 0);
    chk("swh_valid_done", mif.mem_valid, 0);
    cpu_req = 1'b0;
    cyc();

    do_load("lh", 3'b001, 32'h12, 32'h10, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h12, 32'h10, 32'h8001_0000, 32'h0000_8001);

    // lw timeout with ready never asserted
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    mif.mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("tmo_valid", mif.mem_valid, 1);
      chk("tmo_stall", cpu_stall, 1);
      cyc();
    end
    chk("tmo_fault", cpu_fault, 1);
    chk("tmo_rdata", cpu_rdata, 0);
    chk("tmo_valid_done", mif.mem_valid, 0);
    chk("tmo_stall_done", cpu_stall, 0);
    cpu_req = 1'b0;
    cyc();
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h1234_5678;
    cyc();
    mif.mem_rvalid = 1'b0;
    chk("late_rvalid_rdata", cpu_rdata, 0);
    chk("late_rvalid_fault", cpu_fault, 1);

    do_load("lb", 3'b000, 32'h13, 32'h10, 32'h7F00_0000, 32'h0000_007F);

    do_illegal("lw_mis", 1'b0, 3'b010, 32'h0000_0002);
    do_illegal("f3_011", 1'b0, 3'b011, 32'h0000_0000);
    do_illegal("st_f3_100", 1'b1, 3'b100, 32'h0000_0000);

    // reset while in RESP
    issue(1'b0, 3'b010, 32'h0000_0044, 32'h0);
    mif.mem_ready = 1'b1;
    cyc();
    chk("rresp_valid_req", mif.mem_valid, 1);
    cyc();
    chk("rresp_stall", cpu_stall, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rresp_fault_async", cpu_fault, 0);
    chk("rresp_addr_async", mif.mem_addr, 0);
    chk("rresp_valid_async", mif.mem_valid, 0);
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'hAAAA_5555;
    cyc();
    reset_n = 1'b1; cpu_req = 1'b0;
    cyc();
    mif.mem_rvalid = 1'b0;
    chk("rresp_rdata_after", cpu_rdata, 0);

    // reset while in REQ drops mem_valid without a clock edge
    issue(1'b1, 3'b010, 32'h0000_0050, 32'h1111_2222);
    mif.mem_ready = 1'b0;
    cyc();
    chk("rreq_valid", mif.mem_valid, 1);
    #2 reset_n = 1'b0;
    #1 chk("rreq_valid_async", mif.mem_valid, 0);
    cyc();
    reset_n = 1'b1; cpu_req = 1'b0;
    cyc();

    // fresh sw to 0x8 after reset
    issue(1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D);
    mif.mem_ready = 1'b1;
    cyc();
    chk("sw8_valid", mif.mem_valid, 1);
    chk("sw8_addr", mif.mem_addr, 32'h8);
    chk("sw8_wstrb", mif.mem_wstrb, 4'b1111);
    chk("sw8_wdata", mif.mem_wdata, 32'hCAFE_F00D);
    cyc();
    chk("sw8_stall_done", cpu_stall, 0);
    chk("sw8_fault", cpu_fault, 0);
    chk("sw8_valid_done", mif.mem_valid, 0);
    cpu_req = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
